lif_scheduler: RTL and testbench

Time-multiplexed controller that shares one LIF update datapath across `N_NEURONS` virtual neurons. Per-neuron membrane state, refractory counters and input currents are held in local register files; each accepted timestep request sweeps all neurons in index order, one update per clock. It sits between the host-facing pin logic and the spike readout, replacing one physical neuron per input with a single sequenced datapath.

---
 rtl/lif_scheduler_if.sv | 31 +++
 rtl/lif_scheduler.sv | 161 ++++++++++++++++
 tb/tb_lif_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_scheduler_if.sv
// Host-side bundle for lif_scheduler: step handshake, shadow-current writes,
// state readout and the spike stream.
interface lif_scheduler_if #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8
);
    localparam int AW = $clog2(N_NEURONS);

    logic                 step_valid;
    logic                 step_ready;
    logic                 cur_wr_en;
    logic [AW-1:0]        cur_wr_addr;
    logic [WIDTH-1:0]     cur_wr_data;
    logic [AW-1:0]        rd_addr;
    logic [WIDTH-1:0]     rd_state;
    logic                 spk_valid;
    logic [AW-1:0]        spk_id;
    logic                 spk;
    logic                 done;
    logic [N_NEURONS-1:0] spike_vec;

    modport master (
        output step_valid, cur_wr_en, cur_wr_addr, cur_wr_data, rd_addr,
        input  step_ready, rd_state, spk_valid, spk_id, spk, done, spike_vec
    );

    modport slave (
        input  step_valid, cur_wr_en, cur_wr_addr, cur_wr_data, rd_addr,
        output step_ready, rd_state, spk_valid, spk_id, spk, done, spike_vec
    );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF controller: one shared leak/integrate/fire datapath
// swept over N_NEURONS virtual neurons per accepted timestep.
module lif_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    lif_scheduler_if.slave bus
);
    localparam int                AW       = $clog2(N_NEURONS);
    localparam logic [WIDTH:0]    THRESH   = (WIDTH+1)'(THRESHOLD);
    localparam logic [3:0]        REF_LOAD = 4'(REFRACT);
    localparam logic [AW-1:0]     LAST     = AW'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } fsm_t;

    fsm_t                 fsm_reg, fsm_next;
    logic [AW-1:0]        k_reg, k_next;
    logic [N_NEURONS-1:0] acc_reg, acc_next;
    logic [N_NEURONS-1:0] spike_vec_reg, spike_vec_next;
    logic [N_NEURONS-1:0] acc_set;

    logic [WIDTH-1:0]     mem_q    [N_NEURONS];
    logic [WIDTH-1:0]     active_q [N_NEURONS];
    logic [3:0]           ref_q    [N_NEURONS];

    logic                 accept, upd;
    logic                 step_ready, spk_valid, done;
    logic [WIDTH-1:0]     mem_k, cur_k;
    logic [3:0]           ref_k;
    logic [WIDTH:0]       sum_raw;
    logic [WIDTH-1:0]     sum_sat;
    logic                 fire;
    logic [WIDTH-1:0]     mem_new;
    logic [3:0]           ref_new;

    assign accept = (fsm_reg == IDLE) && bus.step_valid;
    assign upd    = (fsm_reg == UPDATE);

    // Shared datapath operates on whichever neuron k_reg points at
    assign mem_k   = mem_q[k_reg];
    assign cur_k   = active_q[k_reg];
    assign ref_k   = ref_q[k_reg];
    assign sum_raw = {1'b0, mem_k >> LEAK_SHIFT} + {1'b0, cur_k};
    assign sum_sat = sum_raw[WIDTH] ? '1 : sum_raw[WIDTH-1:0];

    always_comb begin
        fire    = 1'b0;
        mem_new = sum_sat;
        ref_new = ref_k;
        if (ref_k != 4'd0) begin
            mem_new = '0;
            ref_new = ref_k - 4'd1;
        end else if ({1'b0, sum_sat} >= THRESH) begin
            fire    = 1'b1;
            mem_new = '0;
            ref_new = REF_LOAD;
        end
    end

    // Per-neuron register files; shadow takes host writes at any time,
    // active is frozen from shadow only on step accept.
    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
            logic [WIDTH-1:0] shadow_reg, active_reg, mem_reg;
            logic [3:0]       ref_reg;
            logic             hit;

            assign hit = upd && (k_reg == AW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                    mem_reg    <= '0;
                    ref_reg    <= '0;
                end else begin
                    if (bus.cur_wr_en && (bus.cur_wr_addr == AW'(gi)))
                        shadow_reg <= bus.cur_wr_data;
                    if (accept)
                        active_reg <= shadow_reg;
                    if (hit) begin
                        mem_reg <= mem_new;
                        ref_reg <= ref_new;
                    end
                end
            end

            assign mem_q[gi]    = mem_reg;
            assign active_q[gi] = active_reg;
            assign ref_q[gi]    = ref_reg;
            assign acc_set[gi]  = hit & fire;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            k_reg         <= '0;
            acc_reg       <= '0;
            spike_vec_reg <= '0;
        end else begin
            fsm_reg       <= fsm_next;
            k_reg         <= k_next;
            acc_reg       <= acc_next;
            spike_vec_reg <= spike_vec_next;
        end
    end

    always_comb begin
        fsm_next       = fsm_reg;
        k_next         = k_reg;
        acc_next       = acc_reg;
        spike_vec_next = spike_vec_reg;
        step_ready     = 1'b0;
        spk_valid      = 1'b0;
        done           = 1'b0;
        unique case (fsm_reg)
            IDLE: begin
                step_ready = 1'b1;
                if (accept) begin
                    k_next   = '0;
                    acc_next = '0;
                    fsm_next = UPDATE;
                end
            end
            UPDATE: begin
                spk_valid = 1'b1;
                acc_next  = acc_reg | acc_set;
                // Load the flags at the last update so they are visible during DONE
                if (k_reg == LAST) begin
                    fsm_next       = DONE;
                    spike_vec_next = acc_next;
                end else begin
                    k_next = k_reg + 1'b1;
                end
            end
            DONE: begin
                done     = 1'b1;
                fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign bus.step_ready = step_ready;
    assign bus.spk_valid  = spk_valid;
    assign bus.spk_id     = k_reg;
    assign bus.spk        = upd & fire;
    assign bus.done       = done;
    assign bus.spike_vec  = spike_vec_reg;
    assign bus.rd_state   = mem_q[bus.rd_addr];
endmodule

// File: tb/tb_lif_scheduler.sv
// Directed and randomized checks of lif_scheduler against an arithmetic
// model of the leak/integrate/fire rules and the sweep schedule.
module tb_lif_scheduler;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int THR  = 200;
    localparam int LS   = 1;
    localparam int RF   = 2;
    localparam int MAXV = 255;
    localparam int AW   = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lif_scheduler_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_scheduler #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .THRESHOLD (THR),
        .LEAK_SHIFT(LS),
        .REFRACT   (RF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int m_mem[N], m_ref[N], m_shadow[N], m_active[N];
    int step_no = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = 0; m_ref[i] = 0; m_shadow[i] = 0; m_active[i] = 0;
        end
    endtask

    task automatic check_rd(input string tag, input int a, input int exp);
        bus.rd_addr = AW'(a);
        #1;
        check(tag, 32'(bus.rd_state), 32'(exp));
    endtask

    task automatic check_all_rd(input string tag);
        for (int a = 0; a < N; a++) check_rd(tag, a, m_mem[a]);
    endtask

    task automatic drive_wr(input int a, input int d);
        bus.cur_wr_en   = 1'b1;
        bus.cur_wr_addr = AW'(a);
        bus.cur_wr_data = W'(d);
    endtask

    task automatic wr(input int a, input int d);
        drive_wr(a, d);
        @(posedge clk); #1;
        bus.cur_wr_en = 1'b0;
        m_shadow[a] = d;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One full sweep; wr_at = 0 writes on the accept edge, k+1 during UPDATE k, -1 none
    task automatic do_step(input int wr_at, input int wa, input int wd);
        int budget;
        int exp_vec;
        int s;
        bit f;
        budget = 0;
        while (bus.step_ready !== 1'b1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check("ready_before_step", 32'(bus.step_ready), 32'd1);
        bus.step_valid = 1'b1;
        if (wr_at == 0) drive_wr(wa, wd);
        @(posedge clk); #1;
        bus.step_valid = 1'b0;
        m_active = m_shadow;
        if (wr_at == 0) begin
            m_shadow[wa] = wd;
            bus.cur_wr_en = 1'b0;
        end
        exp_vec = 0;
        for (int k = 0; k < N; k++) begin
            if (wr_at == k + 1) drive_wr(wa, wd);
            f = 1'b0;
            if (m_ref[k] > 0) begin
                m_ref[k] = m_ref[k] - 1;
                m_mem[k] = 0;
            end else begin
                s = m_mem[k] / (1 << LS) + m_active[k];
                if (s > MAXV) s = MAXV;
                if (s >= THR) begin
                    f = 1'b1;
                    m_mem[k] = 0;
                    m_ref[k] = RF;
                end else begin
                    m_mem[k] = s;
                end
            end
            if (f) exp_vec = exp_vec | (1 << k);
            check("spk_valid", 32'(bus.spk_valid), 32'd1);
            check("spk_id", 32'(bus.spk_id), 32'(k));
            check("spk", 32'(bus.spk), 32'(f));
            check("ready_busy", 32'(bus.step_ready), 32'd0);
            check("done_early", 32'(bus.done), 32'd0);
            @(posedge clk); #1;
            if (wr_at == k + 1) begin
                m_shadow[wa] = wd;
                bus.cur_wr_en = 1'b0;
            end
        end
        check("done_pulse", 32'(bus.done), 32'd1);
        check("spike_vec", 32'(bus.spike_vec), 32'(exp_vec));
        check("spk_valid_done", 32'(bus.spk_valid), 32'd0);
        @(posedge clk); #1;
        check("done_clear", 32'(bus.done), 32'd0);
        check("ready_after", 32'(bus.step_ready), 32'd1);
        step_no++;
        $display("step %0d: spike_vec=%b state0=%0d state1=%0d state2=%0d state3=%0d",
                 step_no, bus.spike_vec, m_mem[0], m_mem[1], m_mem[2], m_mem[3]);
        check_all_rd("rd_state_sweep");
    endtask

    int nf_tab[6]   = '{100, 150, 175, 187, 193, 196};
    int fr_tab[7]   = '{120, 180, 0, 0, 0, 120, 180};
    int fr_spk[7]   = '{0, 0, 1, 0, 0, 0, 0};

    initial begin
        bus.step_valid  = 1'b0;
        bus.cur_wr_en   = 1'b0;
        bus.cur_wr_addr = '0;
        bus.cur_wr_data = '0;
        bus.rd_addr     = '0;
        model_clear();

        // Power-on reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.step_ready), 32'd1);
        check("rst_spk_valid", 32'(bus.spk_valid), 32'd0);
        check("rst_spk_id", 32'(bus.spk_id), 32'd0);
        check("rst_spk", 32'(bus.spk), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_spike_vec", 32'(bus.spike_vec), 32'd0);
        check_all_rd("rst_rd_state");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset asserted mid-sweep
        wr(0, 150);
        do_step(-1, 0, 0);
        bus.step_valid = 1'b1;
        @(posedge clk); #1;
        bus.step_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("midrst_ready", 32'(bus.step_ready), 32'd1);
        check("midrst_spk_valid", 32'(bus.spk_valid), 32'd0);
        check("midrst_spk_id", 32'(bus.spk_id), 32'd0);
        check("midrst_spk", 32'(bus.spk), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_spike_vec", 32'(bus.spike_vec), 32'd0);
        check_all_rd("midrst_rd_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check("midrst_no_done", 32'(bus.done), 32'd0);
            @(posedge clk); #1;
        end
        do_step(-1, 0, 0);

        // No-fire convergence on neuron 0
        apply_reset();
        wr(0, 100);
        for (int i = 0; i < 6; i++) begin
            do_step(-1, 0, 0);
            check_rd("nofire_state0", 0, nf_tab[i]);
            check("nofire_spk0", 32'(bus.spike_vec[0]), 32'd0);
        end

        // Fire followed by refractory hold on neuron 1
        apply_reset();
        wr(1, 120);
        for (int i = 0; i < 7; i++) begin
            do_step(-1, 0, 0);
            check_rd("fire_state1", 1, fr_tab[i]);
            check("fire_spk1", 32'(bus.spike_vec[1]), 32'(fr_spk[i]));
        end

        // Saturation and just-below-threshold
        apply_reset();
        wr(2, 255);
        wr(3, 199);
        do_step(-1, 0, 0);
        check_rd("sat_state2", 2, 0);
        check_rd("sat_state3", 3, 199);
        check("sat_spike_vec", 32'(bus.spike_vec), 32'b0100);

        // Double-buffered currents
        apply_reset();
        wr(0, 10);
        do_step(3, 0, 50);
        check_rd("dbuf_mid_write", 0, 10);
        do_step(-1, 0, 0);
        check_rd("dbuf_next_sweep", 0, 55);
        do_step(0, 0, 90);
        check_rd("dbuf_accept_write", 0, 77);
        do_step(-1, 0, 0);
        check_rd("dbuf_accept_next", 0, 128);

        // Back-to-back sweeps with step_valid held high
        apply_reset();
        bus.step_valid = 1'b1;
        @(posedge clk); #1;
        for (int j = 1; j <= 18; j++) begin
            int p;
            p = (j - 1) % 6;
            check("b2b_spk_valid", 32'(bus.spk_valid), 32'(p < 4));
            if (p < 4) check("b2b_spk_id", 32'(bus.spk_id), 32'(p));
            check("b2b_done", 32'(bus.done), 32'(p == 4));
            check("b2b_ready", 32'(bus.step_ready), 32'(p == 5));
            if (j == 18) bus.step_valid = 1'b0;
            @(posedge clk); #1;
        end
        check("b2b_idle_ready", 32'(bus.step_ready), 32'd1);
        check("b2b_idle_valid", 32'(bus.spk_valid), 32'd0);

        // Randomized currents, write timing and sweeps
        apply_reset();
        for (int it = 0; it < 30; it++) begin
            int wa, wd, at;
            if ($urandom_range(1, 0) == 1)
                wr(int'($urandom_range(N - 1, 0)), int'($urandom_range(255, 0)));
            at = int'($urandom_range(N + 1, 0)) - 1;
            wa = int'($urandom_range(N - 1, 0));
            wd = int'($urandom_range(255, 0));
            do_step(at, wa, wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
